defuzz_seq: RTL

- Parametrised, sequential successor of the weighted-average defuzzifier. Computes G = OUT_MAX · (Σw·g) / (Σw), saturated to OUT_MAX.
- Uses a bit-serial restoring divider instead of a combinational divide.
- Adds a start/busy/valid handshake, S_w==0 and saturation flags, and configurable widths and output scale.
- Sits after the rule-aggregation accumulators and feeds the percent output register.

---
 rtl/defuzz_seq_if.sv | 25 ++
 rtl/defuzz_seq.sv | 123 ++++++++++++
 2 files changed

// File: rtl/defuzz_seq_if.sv
// rtl/defuzz_seq_if.sv - operand/result handshake bundle for defuzz_seq
interface defuzz_seq_if #(
  parameter int SW_W  = 24,
  parameter int SWG_W = 32,
  parameter int OUT_W = 8
) ();
  logic             start;
  logic [SW_W-1:0]  S_w;
  logic [SWG_W-1:0] S_wg;
  logic             busy;
  logic             valid;
  logic [OUT_W-1:0] G_out;
  logic             zero_w;
  logic             sat;

  modport master (
    output start, S_w, S_wg,
    input  busy, valid, G_out, zero_w, sat
  );

  modport slave (
    input  start, S_w, S_wg,
    output busy, valid, G_out, zero_w, sat
  );
endinterface

// File: rtl/defuzz_seq.sv
// rtl/defuzz_seq.sv - sequential weighted-average defuzzifier, bit-serial restoring divide
// Optional round-half-up when DEFUZZ_ROUND_EN is defined.
module defuzz_seq #(
  parameter int SW_W    = 24,
  parameter int SWG_W   = 32,
  parameter int FRAC    = 15,
  parameter int OUT_W   = 8,
  parameter int OUT_MAX = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  defuzz_seq_if.slave bus
);
  localparam int NUM_W = SWG_W + $clog2(OUT_MAX + 1) + 1;
  localparam int D_W   = SW_W + FRAC;
  localparam int CNT_W = $clog2(NUM_W);

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           state, state_n;
  logic [NUM_W-1:0] n_reg, n_n, q_reg, q_n, n_calc;
  logic [D_W-1:0]   d_reg, d_n, d_calc, rem_reg, rem_n;
  logic [D_W:0]     rem_sh;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             zp_reg, zp_n;
  logic             valid_r, valid_n, zero_r, zero_n, sat_r, sat_n;
  logic [OUT_W-1:0] g_reg, g_n;

  always_comb begin
    d_calc = {bus.S_w, {FRAC{1'b0}}};
    n_calc = NUM_W'(bus.S_wg) * NUM_W'(OUT_MAX);
`ifdef DEFUZZ_ROUND_EN
    n_calc = n_calc + NUM_W'(d_calc >> 1);
`endif
  end

  always_comb begin
    state_n = state;
    n_n     = n_reg;
    d_n     = d_reg;
    q_n     = q_reg;
    rem_n   = rem_reg;
    cnt_n   = cnt;
    zp_n    = zp_reg;
    valid_n = 1'b0;
    zero_n  = zero_r;
    sat_n   = sat_r;
    g_n     = g_reg;
    rem_sh  = {rem_reg, n_reg[cnt]};
    case (state)
      IDLE: begin
        if (bus.start) begin
          q_n   = '0;
          rem_n = '0;
          if (bus.S_w != '0) begin
            n_n     = n_calc;
            d_n     = d_calc;
            cnt_n   = CNT_W'(NUM_W - 1);
            zp_n    = 1'b0;
            state_n = DIV;
          end else begin
            zp_n    = 1'b1;
            state_n = DONE;
          end
        end
      end
      DIV: begin
        // rem stays below D between steps, so D_W bits suffice once the step is done
        if (rem_sh >= {1'b0, d_reg}) begin
          rem_n = D_W'(rem_sh - {1'b0, d_reg});
          q_n   = {q_reg[NUM_W-2:0], 1'b1};
        end else begin
          rem_n = rem_sh[D_W-1:0];
          q_n   = {q_reg[NUM_W-2:0], 1'b0};
        end
        cnt_n = cnt - 1'b1;
        if (cnt == '0) state_n = DONE;
      end
      DONE: begin
        valid_n = 1'b1;
        sat_n   = (q_reg > NUM_W'(OUT_MAX));
        g_n     = sat_n ? OUT_W'(OUT_MAX) : OUT_W'(q_reg);
        zero_n  = zp_reg;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n_reg   <= '0;
      d_reg   <= '0;
      q_reg   <= '0;
      rem_reg <= '0;
      cnt     <= '0;
      zp_reg  <= 1'b0;
      valid_r <= 1'b0;
      zero_r  <= 1'b0;
      sat_r   <= 1'b0;
      g_reg   <= '0;
    end else begin
      state   <= state_n;
      n_reg   <= n_n;
      d_reg   <= d_n;
      q_reg   <= q_n;
      rem_reg <= rem_n;
      cnt     <= cnt_n;
      zp_reg  <= zp_n;
      valid_r <= valid_n;
      zero_r  <= zero_n;
      sat_r   <= sat_n;
      g_reg   <= g_n;
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.valid  = valid_r;
  assign bus.G_out  = g_reg;
  assign bus.zero_w = zero_r;
  assign bus.sat    = sat_r;
endmodule
